seq_multiplier_4b: RTL and testbench
====================================

Name: seq_multiplier_4b

Overview:
- Sequential 4x4 unsigned shift-and-add multiplier, built around the existing full_adder_4b as its only arithmetic element.
- Sits directly upstream of full_adder_4b: each cycle it drives a, b and carry_in, then consumes sum and carry_out.
- Produces an 8-bit product after a fixed number of cycles, using a start/busy/done handshake.

Parameters:
- N_BITS, 4, operand width; must equal the full_adder_4b width; no other value supported.
- CNT_W, 3, width of the iteration counter; must satisfy 2^CNT_W > N_BITS.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  4  operand M; latched on an accepted start.
- multiplier  input  4  operand Q; latched on an accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  8  result; held stable until the next accepted start.

Behaviour:
- Reset: asserting rst_n low acts immediately, asynchronously, including mid-operation.
  - state goes to IDLE.
  - product, busy, done, internal acc/q/M/carry/counter all go to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at a rising edge: latch M=multiplicand, q=multiplier, acc=0, C=0, cnt=0; go to CALC.
  - start=0: stay in IDLE.
  - product keeps its last value.
- CALC (one iteration per cycle, exactly N_BITS=4 cycles):
  - Adder inputs: a=acc, b = q[0] ? M : 0, carry_in=0.
  - Update: {C,acc,q} <= {carry_out, sum, q} >> 1.
  - cnt increments each cycle; after the cycle where cnt==N_BITS-1, go to DONE.
- DONE: one cycle.
  - product <= {acc,q}, done=1.
  - Return to IDLE.
  - Product is visible the same cycle done is high.
- Latency: start sampled at edge E → busy high on cycles E+1..E+4 → done high and product valid after edge E+5.
- start while busy or in DONE: ignored; operands are not re-latched.
- start held high continuously: a new operation is accepted in the first IDLE cycle, so back-to-back throughput is 1 result per 6 cycles.
- Width: the full 8-bit product is always exact; no overflow is possible (max 0xF*0xF=0xE1).
- busy and done are never high simultaneously.

Optional Feature:
- Macro: SEQ_MUL_ZERO_BYPASS_EN.
- Defined: if multiplicand==0 or multiplier==0 on an accepted start, go IDLE→DONE directly, skipping CALC.
  - product=0x00 and done pulse on the cycle after acceptance.
  - busy never asserts.
- Undefined: zero operands take the full 4-cycle CALC path and yield 0x00 with normal latency.

Decomposition:
- Shared package holds:
  - N_BITS (4) and product width (2*N_BITS).
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - CNT_W.
- Sub-module: instantiate the existing full_adder_4b unchanged (one instance).
- Datapath registers and the FSM live in seq_multiplier_4b; no further sub-modules.

Test Plan:
- Basic: M=0x3, Q=0x5, start pulse → busy 4 cycles, done pulse on the 5th cycle after start, product=0x0F.
- Max: M=0xF, Q=0xF → product=0xE1, done exactly 5 cycles after the start edge.
- Zero: M=0x9, Q=0x0 → product=0x00.
  - Bypass defined: done 1 cycle after start, busy stays 0.
  - Bypass undefined: done at cycle 5.
- Start ignored: start M=0x2, Q=0x7; in CALC cycle 2 pulse start with M=0xA, Q=0xA → product=0x0E, no second done.
- Reset mid-op: start M=0xC, Q=0xB; drive rst_n low in CALC cycle 2 → busy, done, product=0 immediately (before next clk edge).
  - After release, M=0xC, Q=0xB → product=0x84.
- Back-to-back: start held high with 0x4*0x4 then 0x7*0x3 → products 0x10 then 0x15, done pulses 6 cycles apart.

Source files
------------

// File: rtl/seq_multiplier_4b_pkg.sv
// Shared constants for the sequential 4x4 shift-and-add multiplier.
package seq_multiplier_4b_pkg;
    localparam int N_BITS = 4;
    localparam int P_W    = 2 * N_BITS;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_multiplier_4b_if.sv
// start/busy/done handshake plus operands and product of the sequential multiplier.
interface seq_multiplier_4b_if;
    import seq_multiplier_4b_pkg::*;

    logic               start;
    logic [N_BITS-1:0]  multiplicand;
    logic [N_BITS-1:0]  multiplier;
    logic               busy;
    logic               done;
    logic [P_W-1:0]     product;

    modport master (output start, multiplicand, multiplier,
                    input  busy, done, product);
    modport slave  (input  start, multiplicand, multiplier,
                    output busy, done, product);
endinterface

// File: rtl/full_adder_4b.sv
// 4-bit ripple adder with carry in/out; the multiplier's only arithmetic element.
module full_adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0, carry_in};
endmodule

// File: rtl/seq_multiplier_4b.sv
// Sequential 4x4 unsigned shift-and-add multiplier, one adder pass per cycle.
// Optional macro SEQ_MUL_ZERO_BYPASS_EN: zero operands skip CALC and finish in one cycle.
module seq_multiplier_4b
    import seq_multiplier_4b_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    seq_multiplier_4b_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

    state_t             state, state_nxt;
    logic [N_BITS-1:0]  acc, q, m;
    logic [CNT_W-1:0]   cnt;
    logic [P_W-1:0]     product_r;
    logic               done_r;
    logic [N_BITS-1:0]  add_b, sum;
    logic               carry_out;
    logic               zero_op;

    assign add_b = q[0] ? m : '0;

    full_adder_4b u_add (
        .a         (acc),
        .b         (add_b),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry_out)
    );

`ifdef SEQ_MUL_ZERO_BYPASS_EN
    assign zero_op = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = zero_op ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The shifted-out carry is always 0 after the shift, so it lands directly in acc's MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            product_r <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state == ST_DONE);
            case (state)
                ST_IDLE: if (bus.start) begin
                    m   <= bus.multiplicand;
                    q   <= zero_op ? '0 : bus.multiplier;
                    acc <= '0;
                    cnt <= '0;
                end
                ST_CALC: begin
                    acc <= {carry_out, sum[N_BITS-1:1]};
                    q   <= {sum[0], q[N_BITS-1:1]};
                    cnt <= cnt + 1'b1;
                end
                ST_DONE: product_r <= {acc, q};
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == ST_CALC);
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_seq_multiplier_4b.sv
// Self-checking bench for seq_multiplier_4b: vector table, random ops vs. arithmetic model, corner sequences.
module tb_seq_multiplier_4b;
    logic clk = 1'b0;
    logic rst_n;

`ifdef SEQ_MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    seq_multiplier_4b_if bus ();

    seq_multiplier_4b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_overlap = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp_v);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] m, input logic [3:0] q);
        return (BYPASS && (m == 0 || q == 0)) ? 1 : 5;
    endfunction

    function automatic int exp_busy(input logic [3:0] m, input logic [3:0] q);
        return (BYPASS && (m == 0 || q == 0)) ? 0 : 4;
    endfunction

    // Start one op; lat = edges after the accepting edge until done is seen (-1 on timeout).
    task automatic run_op(input logic [3:0] m, input logic [3:0] q,
                          output logic [7:0] prod, output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = m; bus.multiplier = q;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1; prod = '0; bcnt = 0;
        if (bus.busy) bcnt++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.busy && bus.done) n_overlap++;
            if (bus.done) begin
                lat = k; prod = bus.product;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] prod;
        int lat, bcnt, ndone, first_k, second_k;
        logic [7:0] p1, p2;
        logic [3:0] rm, rq;

        vecs[0] = '{4'h3, 4'h5, 8'h0F};
        vecs[1] = '{4'hF, 4'hF, 8'hE1};
        vecs[2] = '{4'h9, 4'h0, 8'h00};
        vecs[3] = '{4'h0, 4'h7, 8'h00};
        vecs[4] = '{4'h1, 4'h1, 8'h01};
        vecs[5] = '{4'h8, 4'h8, 8'h40};
        vecs[6] = '{4'hA, 4'hB, 8'h6E};
        vecs[7] = '{4'h7, 4'hE, 8'h62};

        rst_n = 1'b0; bus.start = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset product", bus.product, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].m, vecs[i].q, prod, lat, bcnt);
            chk($sformatf("vec%0d product", i), prod, vecs[i].exp);
            chk($sformatf("vec%0d latency", i), lat, exp_lat(vecs[i].m, vecs[i].q));
            chk($sformatf("vec%0d busy cycles", i), bcnt, exp_busy(vecs[i].m, vecs[i].q));
        end

        for (int i = 0; i < 30; i++) begin
            rm = 4'($urandom_range(0, 15));
            rq = 4'($urandom_range(0, 15));
            run_op(rm, rq, prod, lat, bcnt);
            chk($sformatf("rand %0h*%0h product", rm, rq), prod, int'(rm) * int'(rq));
            chk($sformatf("rand %0h*%0h latency", rm, rq), lat, exp_lat(rm, rq));
            chk($sformatf("rand %0h*%0h busy", rm, rq), bcnt, exp_busy(rm, rq));
        end

        // start pulsed mid-CALC must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'h2; bus.multiplier = 4'h7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'hA; bus.multiplier = 4'hA;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0; lat = -1; prod = '0;
        for (int k = 3; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin lat = k; prod = bus.product; end
            end
        end
        chk("ignore product", prod, 8'h0E);
        chk("ignore latency", lat, 5);
        chk("ignore done count", ndone, 1);
        chk("ignore product held", bus.product, 8'h0E);

        // asynchronous reset during CALC cycle 2
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'hC; bus.multiplier = 4'hB;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midop busy before reset", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midop reset busy", bus.busy, 0);
        chk("midop reset done", bus.done, 0);
        chk("midop reset product", bus.product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'hC, 4'hB, prod, lat, bcnt);
        chk("after reset product", prod, 8'h84);
        chk("after reset latency", lat, 5);

        // start held high: back-to-back ops
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'h4; bus.multiplier = 4'h4;
        @(posedge clk); #1;
        bus.multiplicand = 4'h7; bus.multiplier = 4'h3;
        first_k = -1; second_k = -1; p1 = '0; p2 = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.busy && bus.done) n_overlap++;
            if (bus.done) begin
                if (first_k < 0) begin first_k = k; p1 = bus.product; end
                else begin
                    second_k = k; p2 = bus.product;
                    bus.start = 1'b0;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b first product", p1, 8'h10);
        chk("b2b second product", p2, 8'h15);
        chk("b2b first latency", first_k, 5);
        chk("b2b spacing", second_k - first_k, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b idle after release", bus.busy, 0);

        chk("busy/done overlap count", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
